mux4_rr_arbiter: RTL and testbench

Round-robin arbiter that shares the 4:1 32-bit select mux (Mux4) feeding the common datapath resource among four requesters. It issues a registered one-hot grant and drives the mux 2-bit select (control) with the granted index. Grants are held until the resource signals completion, the owner withdraws, or a hold-timeout fires. It sits between requesting units and the Mux4 control input.

---
 rtl/mux4_rr_arbiter.sv | 105 ++++++++++
 tb/tb_mux4_rr_arbiter.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter that owns the select of a shared 4:1 datapath mux.
// The grant stays with one owner until done, withdrawal or a hold timeout.
module mux4_rr_arbiter #(
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] req,
    input  logic       done,
    output logic [3:0] grant,
    output logic [1:0] control,
    output logic       grant_valid,
    output logic       timeout
);

    typedef enum logic {IDLE, GRANT} state_t;

    localparam bit             TIMEOUT_EN = (MAX_HOLD != 0);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);

    state_t           state, state_next;
    logic [1:0]       ptr, ptr_next;
    logic [CNT_W-1:0] hold_cnt, hold_cnt_next;
    logic [3:0]       grant_next;
    logic [1:0]       control_next;
    logic             timeout_next;
    logic             do_arb;
    logic [2:0]       win;

    // Returns {found, index}; scanning downward leaves the lowest offset from p as winner.
    function automatic logic [2:0] pick(input logic [3:0] r, input logic [1:0] p);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        for (int k = 3; k >= 0; k--) begin
            idx = p + 2'(k);
            if (r[idx]) res = {1'b1, idx};
        end
        return res;
    endfunction

    always_comb begin
        state_next    = state;
        ptr_next      = ptr;
        hold_cnt_next = hold_cnt;
        grant_next    = grant;
        control_next  = control;
        timeout_next  = 1'b0;
        do_arb        = 1'b0;

        case (state)
            IDLE: do_arb = 1'b1;
            GRANT: begin
                if (done) begin
                    do_arb = 1'b1;
                end else if (!req[control]) begin
                    do_arb = 1'b1;
                end else if (TIMEOUT_EN && hold_cnt == HOLD_LAST) begin
                    do_arb       = 1'b1;
                    timeout_next = 1'b1;
                end else if (TIMEOUT_EN) begin
                    hold_cnt_next = hold_cnt + CNT_W'(1);
                end
                if (do_arb) ptr_next = control + 2'd1;
            end
            default: state_next = IDLE;
        endcase

        // A release re-arbitrates immediately so a waiting requester never sees an idle bubble.
        win = pick(req, ptr_next);
        if (do_arb) begin
            hold_cnt_next = '0;
            if (win[2]) begin
                state_next   = GRANT;
                grant_next   = 4'b0001 << win[1:0];
                control_next = win[1:0];
            end else begin
                state_next = IDLE;
                grant_next = 4'b0000;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            ptr         <= 2'd0;
            hold_cnt    <= '0;
            grant       <= 4'b0000;
            control     <= 2'd0;
            grant_valid <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            state       <= state_next;
            ptr         <= ptr_next;
            hold_cnt    <= hold_cnt_next;
            grant       <= grant_next;
            control     <= control_next;
            grant_valid <= (grant_next != 4'b0000);
            timeout     <= timeout_next;
        end
    end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Bench for mux4_rr_arbiter: directed scenarios then random traffic, all
// compared against a cycle-level model of the round-robin rules.
module tb_mux4_rr_arbiter;

    localparam int MAX_HOLD = 4;
    localparam int CNT_W    = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] req;
    logic       done;
    logic [3:0] grant;
    logic [1:0] control;
    logic       grant_valid;
    logic       timeout;

    int errors = 0;
    int checks = 0;

    // Model state: who owns the resource and how many cycles it has held it.
    bit         m_busy;
    int         m_owner;
    int         m_ptr;
    int         m_held;
    logic [3:0] m_grant;
    logic [1:0] m_ctrl;
    logic       m_to;

    mux4_rr_arbiter #(.MAX_HOLD(MAX_HOLD), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .req(req), .done(done),
        .grant(grant), .control(control), .grant_valid(grant_valid), .timeout(timeout)
    );

    always #5 clk = ~clk;

    function automatic int first_from(input logic [3:0] r, input int p);
        for (int k = 0; k < 4; k++) begin
            if (r[(p + k) % 4]) return (p + k) % 4;
        end
        return -1;
    endfunction

    task automatic model_edge(input logic rst, input logic [3:0] r, input logic d);
        int  winner;
        bit  rel;
        if (rst) begin
            m_busy = 0; m_owner = 0; m_ptr = 0; m_held = 0;
            m_grant = 4'b0000; m_ctrl = 2'd0; m_to = 1'b0;
            return;
        end
        m_to = 1'b0;
        if (!m_busy) begin
            winner = first_from(r, m_ptr);
            if (winner >= 0) begin m_busy = 1; m_owner = winner; m_held = 1; end
        end else begin
            rel = 0;
            if (d) rel = 1;
            else if (!r[m_owner]) rel = 1;
            else if (MAX_HOLD != 0 && m_held == MAX_HOLD) begin rel = 1; m_to = 1'b1; end
            else m_held++;
            if (rel) begin
                m_ptr  = (m_owner + 1) % 4;
                winner = first_from(r, m_ptr);
                if (winner >= 0) begin m_owner = winner; m_held = 1; end
                else m_busy = 0;
            end
        end
        m_grant = m_busy ? (4'b0001 << m_owner) : 4'b0000;
        if (m_busy) m_ctrl = 2'(m_owner);
    endtask

    task automatic checkOutput(input string tag);
        checks++;
        assert (grant === m_grant) else begin
            errors++; $error("FAIL %s.grant observed=%b expected=%b", tag, grant, m_grant);
        end
        checks++;
        assert (control === m_ctrl) else begin
            errors++; $error("FAIL %s.control observed=%0d expected=%0d", tag, control, m_ctrl);
        end
        checks++;
        assert (grant_valid === m_busy) else begin
            errors++; $error("FAIL %s.grant_valid observed=%b expected=%b", tag, grant_valid, m_busy);
        end
        checks++;
        assert (timeout === m_to) else begin
            errors++; $error("FAIL %s.timeout observed=%b expected=%b", tag, timeout, m_to);
        end
    endtask

    task automatic checkFixed(input string tag, input logic [3:0] g, input logic [1:0] c, input logic t);
        checks++;
        assert (grant === g && control === c && timeout === t && grant_valid === (g != 4'b0000)) else begin
            errors++;
            $error("FAIL %s observed grant=%b control=%0d timeout=%b valid=%b expected grant=%b control=%0d timeout=%b",
                   tag, grant, control, timeout, grant_valid, g, c, t);
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic [3:0] r, input logic d, input string tag);
        reset = rst; req = r; done = d;
        @(posedge clk);
        model_edge(rst, r, d);
        #1;
        checkOutput(tag);
    endtask

    initial begin
        reset = 1'b1; req = 4'b0000; done = 1'b0;

        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 4'b1111, 1'b1, "reset_hold");
            checkFixed("reset_hold_fixed", 4'b0000, 2'd0, 1'b0);
        end
        applyStimulus(1'b0, 4'b1111, 1'b0, "reset_release");
        checkFixed("reset_release_fixed", 4'b0001, 2'd0, 1'b0);

        applyStimulus(1'b0, 4'b0000, 1'b1, "to_idle");
        applyStimulus(1'b0, 4'b0100, 1'b0, "single_req");
        checkFixed("single_req_fixed", 4'b0100, 2'd2, 1'b0);
        applyStimulus(1'b0, 4'b0100, 1'b1, "single_regrant");
        checkFixed("single_regrant_fixed", 4'b0100, 2'd2, 1'b0);

        applyStimulus(1'b1, 4'b1111, 1'b0, "rot_reset");
        applyStimulus(1'b0, 4'b1111, 1'b0, "rot_start");
        for (int k = 1; k <= 4; k++) begin
            applyStimulus(1'b0, 4'b1111, 1'b1, "rotation");
            checkFixed("rotation_fixed", 4'b0001 << (k % 4), 2'(k % 4), 1'b0);
        end

        applyStimulus(1'b0, 4'b0010, 1'b1, "owner1");
        checkFixed("owner1_fixed", 4'b0010, 2'd1, 1'b0);
        applyStimulus(1'b0, 4'b1000, 1'b0, "withdraw");
        checkFixed("withdraw_fixed", 4'b1000, 2'd3, 1'b0);

        applyStimulus(1'b0, 4'b0000, 1'b1, "idle_again");
        applyStimulus(1'b0, 4'b0011, 1'b0, "hold_start");
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b0, 4'b0011, 1'b0, "hold");
            checkFixed("hold_fixed", 4'b0001, 2'd0, 1'b0);
        end
        applyStimulus(1'b0, 4'b0011, 1'b0, "forced");
        checkFixed("forced_fixed", 4'b0010, 2'd1, 1'b1);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b0, 4'b0011, 1'b0, "hold1");
        end
        checkFixed("timeout_pulse_end", 4'b0010, 2'd1, 1'b0);
        applyStimulus(1'b0, 4'b0011, 1'b1, "done_vs_timeout");
        checkFixed("done_vs_timeout_fixed", 4'b0001, 2'd0, 1'b0);

        applyStimulus(1'b0, 4'b0100, 1'b1, "owner2");
        checkFixed("owner2_fixed", 4'b0100, 2'd2, 1'b0);
        applyStimulus(1'b1, 4'b0100, 1'b0, "mid_reset");
        checkFixed("mid_reset_fixed", 4'b0000, 2'd0, 1'b0);
        applyStimulus(1'b0, 4'b0110, 1'b0, "post_reset");
        checkFixed("post_reset_fixed", 4'b0010, 2'd1, 1'b0);

        // Requests change only occasionally so owners live long enough to hit the timeout.
        for (int i = 0; i < 400; i++) begin
            logic [3:0] r;
            r = req;
            if ($urandom_range(0, 3) == 0) r = 4'($urandom);
            applyStimulus(($urandom_range(0, 59) == 0), r, ($urandom_range(0, 4) == 0), "random");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
